// File: rtl/pfd_digital.sv
// rtl/pfd_digital.sv - clocked tri-state phase-frequency detector with anti-dead-zone overlap, pulse-width and lock reporting (optional PFD_TIMEOUT_EN)
module pfd_digital #(
    parameter int SYNC_STAGES = 2,
    parameter int PW_W        = 8,
    parameter int MIN_PW      = 2,
    parameter int MAX_PW      = 255,
    parameter int LOCK_TOL    = 1,
    parameter int LOCK_CNT    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            ref_in,
    input  logic            fb_in,
    output logic            upbar,
    output logic            down,
    output logic            lock,
    output logic [PW_W-1:0] pw_last,
    output logic            dir_last,
    output logic            timeout
);

    localparam int HOLD_W = $clog2(MIN_PW + 1);
    localparam int LCK_W  = $clog2(LOCK_CNT + 1);

    localparam logic [PW_W-1:0]   MAX_PW_V   = PW_W'(MAX_PW);
    localparam logic [PW_W-1:0]   LOCK_TOL_V = PW_W'(LOCK_TOL);
    localparam logic [PW_W-1:0]   PW_ONE     = PW_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MIN   = HOLD_W'(MIN_PW);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [LCK_W-1:0]  LOCK_CNT_V = LCK_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DN   = 2'd2,
        S_BOTH = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] ref_sync_q;
    logic [SYNC_STAGES-1:0] fb_sync_q;
    logic                   ref_prev_q;
    logic                   fb_prev_q;
    logic                   ref_rise;
    logic                   fb_rise;

    state_t                 state_q, state_d;
    logic [PW_W-1:0]        cnt_q, cnt_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [LCK_W-1:0]       lock_cnt_q, lock_cnt_d;
    logic [LCK_W-1:0]       lock_cnt_inc;
    logic                   lock_q, lock_d;
    logic [PW_W-1:0]        pw_last_q, pw_last_d;
    logic                   dir_last_q, dir_last_d;
    logic                   timeout_q, timeout_d;
    logic                   upbar_q, down_q;
    logic                   enter_both;
    logic [PW_W-1:0]        pw_new;
    logic                   dir_new;
    logic                   to_hit;

    // Input synchronizers and edge history; they keep running while disabled
    // so that re-enabling never produces a stale rise event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_sync_q <= '0;
            fb_sync_q  <= '0;
            ref_prev_q <= 1'b0;
            fb_prev_q  <= 1'b0;
        end else begin
            ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], ref_in};
            fb_sync_q  <= {fb_sync_q[SYNC_STAGES-2:0], fb_in};
            ref_prev_q <= ref_sync_q[SYNC_STAGES-1];
            fb_prev_q  <= fb_sync_q[SYNC_STAGES-1];
        end
    end

    assign ref_rise = ref_sync_q[SYNC_STAGES-1] & ~ref_prev_q;
    assign fb_rise  = fb_sync_q[SYNC_STAGES-1] & ~fb_prev_q;

`ifdef PFD_TIMEOUT_EN
    assign to_hit = (cnt_q == MAX_PW_V);
`else
    assign to_hit = 1'b0;
`endif

    assign lock_cnt_inc = (lock_cnt_q == LOCK_CNT_V) ? lock_cnt_q : lock_cnt_q + 1'b1;

    // Next-state logic: detector FSM, pulse-width counter, capture and lock update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        lock_cnt_d = lock_cnt_q;
        lock_d     = lock_q;
        pw_last_d  = pw_last_q;
        dir_last_d = dir_last_q;
        timeout_d  = 1'b0;
        enter_both = 1'b0;
        pw_new     = '0;
        dir_new    = 1'b0;

        if (!en) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            hold_d     = '0;
            lock_cnt_d = '0;
            lock_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ref_rise && fb_rise) begin
                        state_d    = S_BOTH;
                        enter_both = 1'b1;
                    end else if (ref_rise) begin
                        state_d = S_UP;
                        cnt_d   = PW_ONE;
                    end else if (fb_rise) begin
                        state_d = S_DN;
                        cnt_d   = PW_ONE;
                    end
                end
                S_UP, S_DN: begin
                    if (to_hit) begin
                        // Opposite edge never arrived: abandon the pulse without overlap.
                        state_d    = S_IDLE;
                        timeout_d  = 1'b1;
                        pw_last_d  = MAX_PW_V;
                        dir_last_d = (state_q == S_UP);
                        cnt_d      = '0;
                        lock_cnt_d = '0;
                        lock_d     = 1'b0;
                    end else if ((state_q == S_UP) ? fb_rise : ref_rise) begin
                        state_d    = S_BOTH;
                        enter_both = 1'b1;
                        pw_new     = cnt_q;
                        dir_new    = (state_q == S_UP);
                    end else if (cnt_q != MAX_PW_V) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (hold_q >= HOLD_MIN) begin
                        state_d = S_IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            endcase

            if (enter_both) begin
                hold_d     = HOLD_ONE;
                cnt_d      = '0;
                pw_last_d  = pw_new;
                dir_last_d = dir_new;
                if (pw_new <= LOCK_TOL_V) begin
                    lock_cnt_d = lock_cnt_inc;
                    lock_d     = (lock_cnt_inc == LOCK_CNT_V);
                end else begin
                    lock_cnt_d = '0;
                    lock_d     = 1'b0;
                end
            end
        end
    end

    // State and output registers; upbar/down come straight from flops to keep the charge pump glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hold_q     <= '0;
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
            pw_last_q  <= '0;
            dir_last_q <= 1'b0;
            timeout_q  <= 1'b0;
            upbar_q    <= 1'b1;
            down_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
            pw_last_q  <= pw_last_d;
            dir_last_q <= dir_last_d;
            timeout_q  <= timeout_d;
            upbar_q    <= ~((state_d == S_UP) || (state_d == S_BOTH));
            down_q     <= (state_d == S_DN) || (state_d == S_BOTH);
        end
    end

    assign upbar    = upbar_q;
    assign down     = down_q;
    assign lock     = lock_q;
    assign pw_last  = pw_last_q;
    assign dir_last = dir_last_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_pfd_digital.sv
// tb/tb_pfd_digital.sv - directed self-checking bench for pfd_digital (MAX_PW=20)
module tb_pfd_digital;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b1;
    logic       ref_in = 1'b0;
    logic       fb_in = 1'b0;
    logic       upbar;
    logic       down;
    logic       lock;
    logic [7:0] pw_last;
    logic       dir_last;
    logic       timeout;

    int pass_cnt = 0;
    int total_cnt = 0;

    pfd_digital #(.MAX_PW(20)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .ref_in   (ref_in),
        .fb_in    (fb_in),
        .upbar    (upbar),
        .down     (down),
        .lock     (lock),
        .pw_last  (pw_last),
        .dir_last (dir_last),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic idle_gap(input int n);
        ref_in = 1'b0;
        fb_in  = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic simul_pulse();
        @(negedge clk);
        ref_in = 1'b1;
        fb_in  = 1'b1;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        idle_gap(4);
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        #2 rst_n = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (upbar !== 1'b1 || down !== 1'b0 || lock !== 1'b0 || pw_last !== 8'd0 ||
                timeout !== 1'b0 || dir_last !== 1'b0) bad++;
            ref_in = k[0];
            fb_in  = k[1];
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL reset_hold: %0d bad cycles, expected 0", bad);
        else pass_cnt++;
        ref_in = 1'b0;
        fb_in  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (upbar !== 1'b1 || down !== 1'b0 || lock !== 1'b0 || timeout !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL reset_release_idle: %0d bad cycles, expected 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_ref_lead();
        logic [31:0] up_obs, up_exp, dn_obs, dn_exp;
        up_obs = '0; up_exp = '0; dn_obs = '0; dn_exp = '0;
        @(negedge clk);
        ref_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            up_obs[k] = upbar;
            dn_obs[k] = down;
            up_exp[k] = !(k >= 3 && k <= 9);
            dn_exp[k] = (k >= 8 && k <= 9);
            if (k == 5) fb_in = 1'b1;
        end
        total_cnt++;
        if (up_obs[3:1] !== 3'b011) $display("FAIL ref_lead_latency: got %b expected 011", up_obs[3:1]);
        else pass_cnt++;
        total_cnt++;
        if (up_obs !== up_exp) $display("FAIL ref_lead_upbar: got %h expected %h", up_obs, up_exp);
        else pass_cnt++;
        total_cnt++;
        if (dn_obs !== dn_exp) $display("FAIL ref_lead_down: got %h expected %h", dn_obs, dn_exp);
        else pass_cnt++;
        total_cnt++;
        if (pw_last !== 8'd5) $display("FAIL ref_lead_pw: got %0d expected 5", pw_last);
        else pass_cnt++;
        total_cnt++;
        if (dir_last !== 1'b1) $display("FAIL ref_lead_dir: got %0d expected 1", dir_last);
        else pass_cnt++;
        idle_gap(4);
    endtask

    task automatic test_fb_lead();
        logic [31:0] up_obs, up_exp, dn_obs, dn_exp;
        up_obs = '0; up_exp = '0; dn_obs = '0; dn_exp = '0;
        @(negedge clk);
        fb_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            up_obs[k] = upbar;
            dn_obs[k] = down;
            up_exp[k] = !(k >= 6 && k <= 7);
            dn_exp[k] = (k >= 3 && k <= 7);
            if (k == 3) ref_in = 1'b1;
        end
        total_cnt++;
        if (dn_obs !== dn_exp) $display("FAIL fb_lead_down: got %h expected %h", dn_obs, dn_exp);
        else pass_cnt++;
        total_cnt++;
        if (up_obs !== up_exp) $display("FAIL fb_lead_upbar: got %h expected %h", up_obs, up_exp);
        else pass_cnt++;
        total_cnt++;
        if (pw_last !== 8'd3) $display("FAIL fb_lead_pw: got %0d expected 3", pw_last);
        else pass_cnt++;
        total_cnt++;
        if (dir_last !== 1'b0) $display("FAIL fb_lead_dir: got %0d expected 0", dir_last);
        else pass_cnt++;
        idle_gap(4);
    endtask

    task automatic test_lock();
        int bad_shape, bad_pw;
        logic lock_k7, lock_k8;
        bad_shape = 0;
        bad_pw = 0;
        lock_k7 = 1'b0;
        lock_k8 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            ref_in = 1'b1;
            fb_in  = 1'b1;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                if ((k == 3 || k == 4) && (upbar !== 1'b0 || down !== 1'b1)) bad_shape++;
                if ((k == 1 || k == 2 || k == 5) && (upbar !== 1'b1 || down !== 1'b0)) bad_shape++;
                if (k == 3 && pw_last !== 8'd0) bad_pw++;
            end
            if (i == 15) begin
                total_cnt++;
                if (lock !== 1'b0) $display("FAIL lock_after_15: got %0d expected 0", lock);
                else pass_cnt++;
            end
            if (i == 16) begin
                total_cnt++;
                if (lock !== 1'b1) $display("FAIL lock_after_16: got %0d expected 1", lock);
                else pass_cnt++;
            end
            idle_gap(4);
        end
        total_cnt++;
        if (bad_shape !== 0) $display("FAIL simul_overlap_shape: %0d bad samples, expected 0", bad_shape);
        else pass_cnt++;
        total_cnt++;
        if (bad_pw !== 0) $display("FAIL simul_pw_zero: %0d bad samples, expected 0", bad_pw);
        else pass_cnt++;
        @(negedge clk);
        ref_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 7) lock_k7 = lock;
            if (k == 8) lock_k8 = lock;
            if (k == 5) fb_in = 1'b1;
        end
        total_cnt++;
        if (lock_k7 !== 1'b1) $display("FAIL lock_before_loss: got %0d expected 1", lock_k7);
        else pass_cnt++;
        total_cnt++;
        if (lock_k8 !== 1'b0) $display("FAIL lock_loss: got %0d expected 0", lock_k8);
        else pass_cnt++;
        idle_gap(4);
    endtask

    task automatic test_timeout();
        logic [31:0] up_obs, up_exp, to_obs, to_exp;
        up_obs = '0; up_exp = '0; to_obs = '0; to_exp = '0;
        @(negedge clk);
        ref_in = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            up_obs[k] = upbar;
            to_obs[k] = timeout;
`ifdef PFD_TIMEOUT_EN
            up_exp[k] = !(k >= 3 && k <= 22);
            to_exp[k] = (k == 23);
`else
            up_exp[k] = !(k >= 3);
            to_exp[k] = 1'b0;
`endif
            ref_in = ((k % 8) < 4);
        end
        total_cnt++;
        if (up_obs !== up_exp) $display("FAIL timeout_upbar: got %h expected %h", up_obs, up_exp);
        else pass_cnt++;
        total_cnt++;
        if (to_obs !== to_exp) $display("FAIL timeout_strobe: got %h expected %h", to_obs, to_exp);
        else pass_cnt++;
`ifdef PFD_TIMEOUT_EN
        total_cnt++;
        if (pw_last !== 8'd20 || dir_last !== 1'b1)
            $display("FAIL timeout_capture: got pw %0d dir %0d expected pw 20 dir 1", pw_last, dir_last);
        else pass_cnt++;
`else
        total_cnt++;
        if (pw_last !== 8'd5) $display("FAIL no_timeout_pw_hold: got %0d expected 5", pw_last);
        else pass_cnt++;
`endif
        ref_in = 1'b0;
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        idle_gap(4);
    endtask

    task automatic test_async_reset();
        logic up_mid;
        @(negedge clk);
        ref_in = 1'b1;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        up_mid = upbar;
        total_cnt++;
        if (up_mid !== 1'b0) $display("FAIL async_rst_pre: got upbar %0d expected 0", up_mid);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (upbar !== 1'b1 || down !== 1'b0 || lock !== 1'b0 || pw_last !== 8'd0 || dir_last !== 1'b0)
            $display("FAIL async_rst_outputs: got upbar %0d down %0d lock %0d pw %0d dir %0d expected 1 0 0 0 0",
                     upbar, down, lock, pw_last, dir_last);
        else pass_cnt++;
        ref_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_gap(4);
    endtask

    task automatic test_en_drop();
        logic dn_mid;
        for (int i = 0; i < 16; i++) simul_pulse();
        total_cnt++;
        if (lock !== 1'b1) $display("FAIL en_drop_prelock: got %0d expected 1", lock);
        else pass_cnt++;
        @(negedge clk);
        fb_in = 1'b1;
        for (int k = 1; k <= 4; k++) @(negedge clk);
        dn_mid = down;
        en = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (dn_mid !== 1'b1) $display("FAIL en_drop_pre: got down %0d expected 1", dn_mid);
        else pass_cnt++;
        total_cnt++;
        if (down !== 1'b0 || upbar !== 1'b1 || lock !== 1'b0)
            $display("FAIL en_drop_outputs: got down %0d upbar %0d lock %0d expected 0 1 0", down, upbar, lock);
        else pass_cnt++;
        total_cnt++;
        if (pw_last !== 8'd0 || dir_last !== 1'b0)
            $display("FAIL en_drop_hold: got pw %0d dir %0d expected 0 0", pw_last, dir_last);
        else pass_cnt++;
        en = 1'b1;
        for (int k = 0; k < 5; k++) @(negedge clk);
        total_cnt++;
        if (down !== 1'b0 || upbar !== 1'b1)
            $display("FAIL en_drop_edge_lost: got down %0d upbar %0d expected 0 1", down, upbar);
        else pass_cnt++;
        idle_gap(4);
    endtask

    initial begin
        test_reset();
        test_ref_lead();
        test_fb_lead();
        test_lock();
        test_timeout();
        test_async_reset();
        test_en_drop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
